imem_loader: RTL

Write-side companion to the instruction memory: accepts a little-endian byte stream and assembles it into 32-bit instruction words. Each word is written into instruction memory through a registered write port, at consecutive word addresses starting from a programmable base. While loading is in progress, the block holds the processor pipeline, so that instruction fetch never reads a partially loaded image. It sits between the host/debug byte source and the instruction memory's write port.

---
 rtl/imem_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream to 32-bit instruction-word loader for the instruction memory write port.
// Holds the CPU pipeline while loading so fetch never sees a partially written image.
module imem_loader #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic [INS_ADDRESS-1:0]   load_base,
    input  logic [INS_ADDRESS-2:0]   load_words,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     wr_en,
    output logic [INS_ADDRESS-1:0]   wr_addr,
    output logic [INS_W-1:0]         wr_data,
    output logic                     cpu_hold,
    output logic                     load_done
);

    // state | meaning
    // IDLE  | waiting for load_start
    // RECV  | accepting bytes of the current word
    // WRITE | one-cycle write strobe of the assembled word
    // DONE  | one-cycle load_done pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [INS_ADDRESS-1:0]   addr_q, addr_d;
    logic [INS_ADDRESS-2:0]   words_left_q, words_left_d;
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic [INS_W-1:0]         word_q, word_d;
    logic                     byte_ready_q, byte_ready_d;
    logic                     wr_en_q, wr_en_d;
    logic [INS_ADDRESS-1:0]   wr_addr_q, wr_addr_d;
    logic [INS_W-1:0]         wr_data_q, wr_data_d;
    logic                     cpu_hold_q, cpu_hold_d;
    logic                     load_done_q, load_done_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    addr_d       = load_base & ~INS_ADDRESS'(3);
                    words_left_d = load_words;
                    byte_cnt_d   = 2'd0;
                    state_d      = (load_words == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (byte_valid) begin
                    word_d[8*byte_cnt_q +: 8] = byte_data;
                    byte_cnt_d                = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d       = addr_q + INS_ADDRESS'(4);
                words_left_d = words_left_q - (INS_ADDRESS-1)'(1);
                state_d      = (words_left_q == (INS_ADDRESS-1)'(1)) ? DONE : RECV;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they never depend combinationally on inputs.
        byte_ready_d = (state_d == RECV);
        wr_en_d      = (state_d == WRITE);
        cpu_hold_d   = (state_d != IDLE);
        load_done_d  = (state_d == DONE);
        wr_addr_d    = (state_d == WRITE) ? addr_d : wr_addr_q;
        wr_data_d    = (state_d == WRITE) ? word_d : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            byte_cnt_q   <= 2'd0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;

endmodule
